// File: rtl/boot_rom_fetch_pkg.sv
// Shared types and default parameters for the boot ROM fetch bridge.
package boot_rom_fetch_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_8000;
  localparam int unsigned DEF_ROM_AW    = 10;
  localparam int unsigned DEF_ROM_WORDS = 548;
  localparam int unsigned DEF_FIFO_DEPTH = 2;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rom_resp_t;

endpackage

// File: rtl/boot_rom_fetch_bridge_if.sv
// Instruction-fetch handshake bundle: req/gnt/addr request side, rvalid/rready/rdata/err response side.
interface boot_rom_fetch_bridge_if;

  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic        instr_rready_i;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  modport master (
    output instr_req_i, instr_addr_i, instr_rready_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i, instr_rready_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );

endinterface

// File: rtl/boot_rom_resp_fifo.sv
// Synchronous response FIFO of rom_resp_t; head is read straight from the storage registers.
module boot_rom_resp_fifo
  import boot_rom_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  rom_resp_t        wdata,
  output rom_resp_t        rdata,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rom_resp_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop && (count == CNT_W'(DEPTH))));

  a_no_underflow : assert property (@(posedge CLK) disable iff (RST)
    !(pop && (count == '0)));

endmodule

// File: rtl/boot_rom_fetch_bridge.sv
// Fetch-port to boot-ROM bridge: window decode, credit-based grant, one-cycle ROM pipeline, in-order response buffer.
// Optional BOOT_ROM_FETCH_ALIGN_CHECK_EN: misaligned fetches return an error beat without touching the ROM.
module boot_rom_fetch_bridge
  import boot_rom_fetch_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int unsigned ROM_AW     = DEF_ROM_AW,
  parameter int unsigned ROM_WORDS  = DEF_ROM_WORDS,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  boot_rom_fetch_bridge_if.slave  fetch,
  output logic                    rom_csn_o,
  output logic [ROM_AW-1:0]       rom_a_o,
  input  logic [31:0]             rom_q_i,
  output logic                    busy_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic             hit;
  logic             gnt;
  logic             pop;
  logic             inflight;
  logic             inflight_err;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] count;
  rom_resp_t        push_data;
  rom_resp_t        head;

  assign rom_a_o = fetch.instr_addr_i[ROM_AW+1:2];

  // Window decode: tag match on upper bits plus populated-word bound.
  always_comb begin
    hit = (fetch.instr_addr_i[31:ROM_AW+2] == BASE_ADDR[31:ROM_AW+2]) &&
          (32'(rom_a_o) < 32'(ROM_WORDS));
`ifdef BOOT_ROM_FETCH_ALIGN_CHECK_EN
    if (fetch.instr_addr_i[1:0] != 2'b00) hit = 1'b0;
`endif
  end

`ifndef BOOT_ROM_FETCH_ALIGN_CHECK_EN
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^fetch.instr_addr_i[1:0];
`endif

  // A same-cycle pop frees a slot, which is what sustains one fetch per cycle.
  assign pop = fetch.instr_rvalid_o && fetch.instr_rready_i;
  assign occ = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign gnt = fetch.instr_req_i && !RST && (occ < OCC_W'(FIFO_DEPTH));

  assign rom_csn_o         = !(gnt && hit);
  assign fetch.instr_gnt_o = gnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
    end else begin
      inflight     <= gnt;
      inflight_err <= !hit;
    end
  end

  // Error beats travel through the same stage as ROM reads, keeping order intact.
  always_comb begin
    push_data.err  = inflight_err;
    push_data.data = inflight_err ? 32'h0 : rom_q_i;
  end

  boot_rom_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (inflight),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .count (count)
  );

  assign fetch.instr_rvalid_o = (count != '0);
  assign fetch.instr_rdata_o  = head.data;
  assign fetch.instr_err_o    = head.err;
  assign busy_o               = inflight || (count != '0);

endmodule

// File: tb/tb_boot_rom_fetch_bridge.sv
// Directed bench for boot_rom_fetch_bridge with a registered-read ROM model and a beat scoreboard.
module tb_boot_rom_fetch_bridge;

  logic        CLK;
  logic        RST;
  logic        rom_csn;
  logic [9:0]  rom_a;
  logic [31:0] rom_q;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int          pop_cyc[$];

  boot_rom_fetch_bridge_if fetch_if ();

  boot_rom_fetch_bridge dut (
    .CLK       (CLK),
    .RST       (RST),
    .fetch     (fetch_if),
    .rom_csn_o (rom_csn),
    .rom_a_o   (rom_a),
    .rom_q_i   (rom_q),
    .busy_o    (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_val(input logic [9:0] idx);
    return 32'h0000_0013 | (32'(idx) << 12);
  endfunction

  // Expected beat for a granted address: window 0x8000..0x888F, word index < 548.
  function automatic logic [32:0] model(input logic [31:0] a);
    logic ok;
    ok = (a[31:12] == 20'h00008) && (a[11:2] < 10'd548);
`ifdef BOOT_ROM_FETCH_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) ok = 1'b0;
`endif
    return ok ? {1'b0, rom_val(a[11:2])} : {1'b1, 32'h0};
  endfunction

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!rom_csn) rom_q <= rom_val(rom_a);
  end

  always @(negedge CLK) begin
    if (RST) begin
      got_q.delete();
      exp_q.delete();
      pop_cyc.delete();
    end else begin
      if (fetch_if.instr_gnt_o) exp_q.push_back(model(fetch_if.instr_addr_i));
      if (fetch_if.instr_rvalid_o && fetch_if.instr_rready_i) begin
        got_q.push_back({fetch_if.instr_err_o, fetch_if.instr_rdata_o});
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic flush();
    got_q.delete();
    exp_q.delete();
    pop_cyc.delete();
  endtask

  task automatic check_beats(input string tag, input int n);
    check({tag, "_ngot"}, 64'(got_q.size()), 64'(n));
    check({tag, "_nexp"}, 64'(exp_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    logic g;
    logic [31:0] held;

    RST = 1'b1;
    rom_q = 32'h0;
    fetch_if.instr_req_i    = 1'b0;
    fetch_if.instr_addr_i   = 32'h0;
    fetch_if.instr_rready_i = 1'b1;

    // Reset state, and request blocked while RST is high.
    repeat (2) tick();
    fetch_if.instr_req_i  = 1'b1;
    fetch_if.instr_addr_i = 32'h0000_8000;
    #1;
    check("rst_rvalid", 64'(fetch_if.instr_rvalid_o), 64'd0);
    check("rst_err",    64'(fetch_if.instr_err_o),    64'd0);
    check("rst_rdata",  64'(fetch_if.instr_rdata_o),  64'd0);
    check("rst_busy",   64'(busy),                    64'd0);
    check("rst_gnt",    64'(fetch_if.instr_gnt_o),    64'd0);
    check("rst_csn",    64'(rom_csn),                 64'd1);
    fetch_if.instr_req_i = 1'b0;
    tick();
    RST = 1'b0;

    // Test 1: single fetch.
    tick();
    flush();
    fetch_if.instr_req_i  = 1'b1;
    fetch_if.instr_addr_i = 32'h0000_8000;
    #1;
    check("t1_gnt", 64'(fetch_if.instr_gnt_o), 64'd1);
    check("t1_csn", 64'(rom_csn), 64'd0);
    check("t1_a",   64'(rom_a),   64'd0);
    tick();
    fetch_if.instr_req_i = 1'b0;
    #1;
    check("t1_rvalid_t1", 64'(fetch_if.instr_rvalid_o), 64'd0);
    check("t1_busy_t1",   64'(busy), 64'd1);
    tick();
    #1;
    check("t1_rvalid_t2", 64'(fetch_if.instr_rvalid_o), 64'd1);
    check("t1_rdata",     64'(fetch_if.instr_rdata_o),  64'h13);
    check("t1_err",       64'(fetch_if.instr_err_o),    64'd0);
    tick();
    #1;
    check("t1_rvalid_t3", 64'(fetch_if.instr_rvalid_o), 64'd0);
    check("t1_busy_t3",   64'(busy), 64'd0);

    // Test 2: 16 back-to-back fetches with rready held high.
    tick();
    flush();
    for (int i = 0; i < 16; i++) begin
      fetch_if.instr_req_i  = 1'b1;
      fetch_if.instr_addr_i = 32'h0000_8000 + 32'(4 * i);
      #1;
      check($sformatf("t2_gnt%0d", i), 64'(fetch_if.instr_gnt_o), 64'd1);
      tick();
    end
    fetch_if.instr_req_i = 1'b0;
    repeat (4) tick();
    check_beats("t2", 16);
    if (pop_cyc.size() == 16)
      check("t2_span", 64'(pop_cyc[15] - pop_cyc[0]), 64'd15);
    else
      check("t2_span_n", 64'(pop_cyc.size()), 64'd16);

    // Test 3: index 548 and address 0 are both out of window.
    flush();
    fetch_if.instr_req_i  = 1'b1;
    fetch_if.instr_addr_i = 32'h0000_8890;
    #1;
    check("t3_gnt0", 64'(fetch_if.instr_gnt_o), 64'd1);
    check("t3_csn0", 64'(rom_csn), 64'd1);
    tick();
    fetch_if.instr_addr_i = 32'h0000_0000;
    #1;
    check("t3_gnt1", 64'(fetch_if.instr_gnt_o), 64'd1);
    check("t3_csn1", 64'(rom_csn), 64'd1);
    tick();
    fetch_if.instr_req_i = 1'b0;
    repeat (4) tick();
    check_beats("t3", 2);
    for (int i = 0; i < 2 && i < got_q.size(); i++)
      check($sformatf("t3_errbeat%0d", i), 64'(got_q[i]), 64'h1_0000_0000);

    // Test 4: stall with req held; exactly two grants, then resume.
    flush();
    grants = 0;
    fetch_if.instr_rready_i = 1'b0;
    fetch_if.instr_req_i    = 1'b1;
    fetch_if.instr_addr_i   = 32'h0000_8040;
    for (int c = 0; c < 6; c++) begin
      #1;
      g = fetch_if.instr_gnt_o;
      if (g) grants++;
      tick();
      if (g) fetch_if.instr_addr_i = fetch_if.instr_addr_i + 32'd4;
    end
    #1;
    check("t4_grants", 64'(grants), 64'd2);
    check("t4_gnt_stalled", 64'(fetch_if.instr_gnt_o), 64'd0);
    check("t4_rvalid", 64'(fetch_if.instr_rvalid_o), 64'd1);
    held = fetch_if.instr_rdata_o;
    check("t4_head", 64'(held), 64'h0001_0013);
    tick();
    #1;
    check("t4_stable", 64'(fetch_if.instr_rdata_o), 64'(held));
    check("t4_stable_err", 64'(fetch_if.instr_err_o), 64'd0);
    fetch_if.instr_rready_i = 1'b1;
    #1;
    check("t4_resume_gnt", 64'(fetch_if.instr_gnt_o), 64'd1);
    for (int c = 0; c < 4; c++) begin
      #1;
      g = fetch_if.instr_gnt_o;
      if (g) grants++;
      tick();
      if (g) fetch_if.instr_addr_i = fetch_if.instr_addr_i + 32'd4;
    end
    fetch_if.instr_req_i = 1'b0;
    repeat (5) tick();
    check("t4_total_grants", 64'(grants), 64'd6);
    check_beats("t4", 6);

    // Test 5: reset with one beat buffered and one in flight.
    flush();
    fetch_if.instr_rready_i = 1'b0;
    fetch_if.instr_req_i    = 1'b1;
    fetch_if.instr_addr_i   = 32'h0000_8010;
    tick();
    fetch_if.instr_addr_i = 32'h0000_8014;
    tick();
    fetch_if.instr_addr_i = 32'h0000_8018;
    #1;
    check("t5_pre_rvalid", 64'(fetch_if.instr_rvalid_o), 64'd1);
    check("t5_pre_busy",   64'(busy), 64'd1);
    RST = 1'b1;
    #1;
    check("t5_rst_rvalid", 64'(fetch_if.instr_rvalid_o), 64'd0);
    check("t5_rst_busy",   64'(busy), 64'd0);
    check("t5_rst_gnt",    64'(fetch_if.instr_gnt_o), 64'd0);
    check("t5_rst_csn",    64'(rom_csn), 64'd1);
    fetch_if.instr_req_i = 1'b0;
    tick();
    RST = 1'b0;
    fetch_if.instr_rready_i = 1'b1;
    tick();
    flush();
    fetch_if.instr_req_i  = 1'b1;
    fetch_if.instr_addr_i = 32'h0000_8020;
    #1;
    check("t5_gnt", 64'(fetch_if.instr_gnt_o), 64'd1);
    tick();
    fetch_if.instr_req_i = 1'b0;
    repeat (4) tick();
    check_beats("t5", 1);
    if (got_q.size() > 0) check("t5_own_data", 64'(got_q[0]), 64'h0_0000_8013);

    // Test 6: misaligned fetch.
    flush();
    fetch_if.instr_req_i  = 1'b1;
    fetch_if.instr_addr_i = 32'h0000_8002;
    #1;
    check("t6_gnt", 64'(fetch_if.instr_gnt_o), 64'd1);
`ifdef BOOT_ROM_FETCH_ALIGN_CHECK_EN
    check("t6_csn", 64'(rom_csn), 64'd1);
`else
    check("t6_csn", 64'(rom_csn), 64'd0);
    check("t6_a",   64'(rom_a),   64'd0);
`endif
    tick();
    fetch_if.instr_req_i = 1'b0;
    repeat (3) tick();
    check("t6_n", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) begin
`ifdef BOOT_ROM_FETCH_ALIGN_CHECK_EN
      check("t6_beat", 64'(got_q[0]), 64'h1_0000_0000);
`else
      check("t6_beat", 64'(got_q[0]), 64'h0_0000_0013);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
